keypad_scanner: RTL

//   Scans a 4x4 active-low matrix keypad; produces the debounced key code and level-held pressed flag
//   (keyboard_data / IsPressed) consumed by the mode-switch and keyboard-note logic.
//   One column driven low at a time; rows sampled through a 2-flop synchronizer.
//   A scan is accepted only when exactly one key is down; press and release each need N consistent scans.

---
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the debounced key outputs.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keyboard_data;
  logic       IsPressed;

  modport master (input row_in, output col_out, keyboard_data, IsPressed);
  modport slave  (output row_in, input col_out, keyboard_data, IsPressed);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-scan debounce of single-key presses and releases.
// Columns are driven one-cold; rows pass through a 2-flop synchronizer before sampling.
module keypad_scanner #(
  parameter int SCAN_DIV       = 12_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  keypad_scanner_if.master kp
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} state_t;

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic [3:0]        col_q;
  logic [3:0]        row_p0, row_p1;
  logic [11:0]       scan_bits;
  logic [15:0]       closed;
  logic [1:0]        n_keys;
  logic [3:0]        key_pos;
  logic              slot_end, scan_end, one_key, no_key;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [3:0]        cand_q, cand_n;
  logic [3:0]        key_q, key_n;
  logic              pressed_q, pressed_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  // pos = {column, row}
  function automatic logic [3:0] key_code(input logic [3:0] pos);
    case (pos)
      4'b00_00: key_code = 4'h1;  4'b00_01: key_code = 4'h4;
      4'b00_10: key_code = 4'h7;  4'b00_11: key_code = 4'hE;
      4'b01_00: key_code = 4'h2;  4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h8;  4'b01_11: key_code = 4'h0;
      4'b10_00: key_code = 4'h3;  4'b10_01: key_code = 4'h6;
      4'b10_10: key_code = 4'h9;  4'b10_11: key_code = 4'hF;
      4'b11_00: key_code = 4'hA;  4'b11_01: key_code = 4'hB;
      4'b11_10: key_code = 4'hC;  default:  key_code = 4'hD;
    endcase
  endfunction

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign scan_end = slot_end && (col_idx == 2'd3);
  // Column 3 is judged from the live synchronizer output on the scan-ending edge.
  assign closed   = {~row_p1, scan_bits};

  // Stage p0/p1: row synchronizer; column slot timing and per-column capture
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      col_q     <= 4'b1110;
      row_p0    <= 4'hF;
      row_p1    <= 4'hF;
      scan_bits <= '0;
    end else begin
      row_p0 <= kp.row_in;
      row_p1 <= row_p0;
      if (slot_end) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col_q    <= {col_q[2:0], col_q[3]};
        case (col_idx)
          2'd0:    scan_bits[3:0]  <= ~row_p1;
          2'd1:    scan_bits[7:4]  <= ~row_p1;
          2'd2:    scan_bits[11:8] <= ~row_p1;
          default: ;
        endcase
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  always_comb begin
    n_keys  = 2'd0;
    key_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (closed[i]) begin
        key_pos = 4'(i);
        if (n_keys != 2'd2) n_keys = n_keys + 2'd1;
      end
    end
  end

  assign one_key = (n_keys == 2'd1);
  assign no_key  = (n_keys == 2'd0);

  // Stage p2: debounce FSM, evaluated once per full scan
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      key_q     <= 4'h0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      cand_q    <= cand_n;
      key_q     <= key_n;
      pressed_q <= pressed_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    cand_n    = cand_q;
    key_n     = key_q;
    pressed_n = pressed_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (one_key) begin
            cand_n = key_code(key_pos);
            cnt_n  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_n   = PRESSED;
              key_n     = key_code(key_pos);
              pressed_n = 1'b1;
              cnt_n     = '0;
            end else begin
              state_n = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (one_key && key_code(key_pos) == cand_q) begin
            cnt_n = sat_inc(cnt_q);
            if (sat_inc(cnt_q) >= CNT_MAX) begin
              state_n   = PRESSED;
              key_n     = cand_q;
              pressed_n = 1'b1;
              cnt_n     = '0;
            end
          end else if (one_key) begin
            cand_n = key_code(key_pos);
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (no_key) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n   = IDLE;
              pressed_n = 1'b0;
              cnt_n     = '0;
            end else begin
              state_n = RELEASE_DEB;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        RELEASE_DEB: begin
          if (no_key) begin
            cnt_n = sat_inc(cnt_q);
            if (sat_inc(cnt_q) >= CNT_MAX) begin
              state_n   = IDLE;
              pressed_n = 1'b0;
              cnt_n     = '0;
            end
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign kp.col_out       = col_q;
  assign kp.keyboard_data = key_q;
  assign kp.IsPressed     = pressed_q;

endmodule
